// File: rtl/tight_acc_pkg.sv
// Shared opcodes, default geometry and controller state encoding for the
// tightly-coupled matrix-multiply accelerator.
package tight_acc_pkg;

    localparam int N_DEF      = 10;
    localparam int DATA_W_DEF = 64;

    localparam logic [5:0] OP_INIT   = 6'd10;
    localparam logic [5:0] OP_FILLA  = 6'd11;
    localparam logic [5:0] OP_FILLB  = 6'd12;
    localparam logic [5:0] OP_RESULT = 6'd13;
    localparam logic [5:0] OP_MULT   = 6'd25;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_MAC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WB    = 3'd4,
        ST_RD    = 3'd5,
        ST_RESP  = 3'd6
    } state_t;

endpackage

// File: rtl/tight_acc_mm_mac.sv
// Single multiply-accumulate unit; the controller decides when to clear and
// when to add. Products and sums wrap modulo 2^DATA_W.
module tight_acc_mm_mac #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] acc
);

    // Accumulator register: clear has priority over accumulate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + a * b;
        end else begin
            acc <= acc;
        end
    end

endmodule

// File: rtl/tight_acc_mm_ctrl.sv
// Command sequencer for the matrix-multiply accelerator: fills A/B, clears all
// stores, runs the i/j/k MAC schedule into R and streams R back to the core.
module tight_acc_mm_ctrl
    import tight_acc_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = $clog2(N * N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_val,
    output logic              busy,
    input  logic [5:0]        cmd_opcode,
    input  logic [DATA_W-1:0] cmd_config_data,
    output logic              resp_val,
    input  logic              resp_rdy,
    output logic [DATA_W-1:0] resp_data,
    output logic              a_en,
    output logic              a_we,
    output logic [AW-1:0]     a_addr,
    output logic [DATA_W-1:0] a_wdata,
    input  logic [DATA_W-1:0] a_rdata,
    output logic              b_en,
    output logic              b_we,
    output logic [AW-1:0]     b_addr,
    output logic [DATA_W-1:0] b_wdata,
    input  logic [DATA_W-1:0] b_rdata,
    output logic              r_en,
    output logic              r_we,
    output logic [AW-1:0]     r_addr,
    output logic [DATA_W-1:0] r_wdata,
    input  logic [DATA_W-1:0] r_rdata
);

    localparam int            IW        = $clog2(N);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N * N - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

    state_t            state_r;
    logic [AW-1:0]     fa_ptr_r;
    logic [AW-1:0]     fb_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW-1:0]     clr_ptr_r;
    logic [IW-1:0]     i_r;
    logic [IW-1:0]     j_r;
    logic [IW-1:0]     k_r;
    logic [DATA_W-1:0] resp_data_r;
    logic              resp_cap_r;
    logic [DATA_W-1:0] acc_s;
    logic              accept_s;
    logic              mac_clr_s;
    logic              mac_en_s;

    function automatic logic [AW-1:0] flat_addr(input logic [IW-1:0] row,
                                                 input logic [IW-1:0] col);
        return AW'(int'(row) * N + int'(col));
    endfunction

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + AW'(1);
    endfunction

    // Gating with rst keeps fill strobes dead while reset is held
    assign accept_s  = cmd_val && !rst && (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign resp_val  = (state_r == ST_RESP);
    // First RESP cycle forwards the store output while it is being captured
    assign resp_data = (state_r == ST_RESP && !resp_cap_r) ? r_rdata : resp_data_r;

    assign mac_clr_s = (accept_s && cmd_opcode == OP_MULT) || (state_r == ST_WB);
    assign mac_en_s  = (state_r == ST_MAC && k_r != '0) || (state_r == ST_DRAIN);

    tight_acc_mm_mac #(.DATA_W(DATA_W)) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr_s),
        .en  (mac_en_s),
        .a   (a_rdata),
        .b   (b_rdata),
        .acc (acc_s)
    );

    // Store port drive: fills in IDLE, otherwise whichever sequencing state owns the stores
    always_comb begin
        a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_en = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        r_en = 1'b0; r_we = 1'b0; r_addr = '0; r_wdata = '0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && cmd_opcode == OP_FILLA) begin
                    a_en = 1'b1; a_we = 1'b1; a_addr = fa_ptr_r; a_wdata = cmd_config_data;
                end else if (accept_s && cmd_opcode == OP_FILLB) begin
                    b_en = 1'b1; b_we = 1'b1; b_addr = fb_ptr_r; b_wdata = cmd_config_data;
                end else begin
                    a_en = 1'b0;
                end
            end
            ST_CLEAR: begin
                a_en = 1'b1; a_we = 1'b1; a_addr = clr_ptr_r;
                b_en = 1'b1; b_we = 1'b1; b_addr = clr_ptr_r;
                r_en = 1'b1; r_we = 1'b1; r_addr = clr_ptr_r;
            end
            ST_MAC: begin
                a_en = 1'b1; a_addr = flat_addr(i_r, k_r);
                b_en = 1'b1; b_addr = flat_addr(k_r, j_r);
            end
            ST_WB: begin
                r_en = 1'b1; r_we = 1'b1; r_addr = flat_addr(i_r, j_r); r_wdata = acc_s;
            end
            ST_RD: begin
                r_en = 1'b1; r_addr = rd_ptr_r;
            end
            default: begin
                a_en = 1'b0;
            end
        endcase
    end

    // Controller FSM with pointers, loop indices and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            fa_ptr_r    <= '0;
            fb_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            clr_ptr_r   <= '0;
            i_r         <= '0;
            j_r         <= '0;
            k_r         <= '0;
            resp_data_r <= '0;
            resp_cap_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_val) begin
                        case (cmd_opcode)
                            OP_FILLA: fa_ptr_r <= ptr_inc(fa_ptr_r);
                            OP_FILLB: fb_ptr_r <= ptr_inc(fb_ptr_r);
                            OP_INIT: begin
                                fa_ptr_r  <= '0;
                                fb_ptr_r  <= '0;
                                rd_ptr_r  <= '0;
                                clr_ptr_r <= '0;
                                state_r   <= ST_CLEAR;
                            end
                            OP_MULT: begin
                                i_r     <= '0;
                                j_r     <= '0;
                                k_r     <= '0;
                                state_r <= ST_MAC;
                            end
                            OP_RESULT: state_r <= ST_RD;
                            default:   state_r <= ST_IDLE;
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (clr_ptr_r == LAST_ADDR) begin
                        clr_ptr_r <= '0;
                        state_r   <= ST_IDLE;
                    end else begin
                        clr_ptr_r <= clr_ptr_r + AW'(1);
                    end
                end
                ST_MAC: begin
                    if (k_r == LAST_IDX) begin
                        k_r     <= '0;
                        state_r <= ST_DRAIN;
                    end else begin
                        k_r <= k_r + IW'(1);
                    end
                end
                ST_DRAIN: state_r <= ST_WB;
                ST_WB: begin
                    if (j_r == LAST_IDX) begin
                        j_r <= '0;
                        if (i_r == LAST_IDX) begin
                            i_r     <= '0;
                            state_r <= ST_IDLE;
                        end else begin
                            i_r     <= i_r + IW'(1);
                            state_r <= ST_MAC;
                        end
                    end else begin
                        j_r     <= j_r + IW'(1);
                        state_r <= ST_MAC;
                    end
                end
                ST_RD: begin
                    resp_cap_r <= 1'b0;
                    state_r    <= ST_RESP;
                end
                ST_RESP: begin
                    if (!resp_cap_r) begin
                        resp_data_r <= r_rdata;
                        resp_cap_r  <= 1'b1;
                    end else begin
                        resp_cap_r  <= 1'b1;
                    end
                    if (resp_rdy) begin
                        rd_ptr_r <= ptr_inc(rd_ptr_r);
                        state_r  <= ST_IDLE;
                    end else begin
                        state_r  <= ST_RESP;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule
